// File: rtl/dst_stream_fifo_if.sv
// dst_stream_fifo_if
//    Valid/ready word stream carrying a data word and a packet-end flag.
//    master drives valid/data/last and observes ready; slave is the mirror.
//
//    valid  word present on data/last
//    data   DW-bit payload (fp32 bit pattern)
//    last   word ends the packet
//    ready  receiver can take the word this cycle
interface dst_stream_fifo_if #(
   parameter int DW = 32
);
   logic          valid;
   logic [DW-1:0] data;
   logic          last;
   logic          ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/dst_stream_fifo.sv
// dst_stream_fifo
//    Output-side buffer between the accelerator dst stream and the DMA write
//    master. A first-word-fall-through FIFO absorbs DMA backpressure, and an
//    input-side beat counter checks every packet against the programmed
//    length, forcing a correct last flag toward the DMA.
//
//    clk      clock
//    rst_n    asynchronous active-low reset
//    clr      synchronous flush: empties FIFO, zeroes beat counter, clears len_err
//    len      expected words per packet; 0 disables the length check
//    s        upstream stream (slave side, s.ready = dst_ready)
//    m        downstream stream toward the DMA (master side)
//    count    current occupancy
//    len_err  sticky length-mismatch flag
module dst_stream_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int LW    = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [LW-1:0]            len,
   dst_stream_fifo_if.slave         s,
   dst_stream_fifo_if.master        m,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     len_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   // Each entry is {last_out, data}.
   logic [DW:0]   mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [LW-1:0] beat_r;
   logic          len_err_r;

   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          last_out_s;
   logic          err_s;
   logic [LW-1:0] beat_nxt_s;
   logic [DW:0]   head_s;

   // Status is decoded from the registered count only, so a pop never opens
   // s.ready in the same cycle and an empty FIFO never bypasses s to m.
   assign full_s  = (count_r == FULL_C);
   assign empty_s = (count_r == {CW{1'b0}});
   assign push_s  = s.valid & ~full_s & ~clr;
   assign pop_s   = ~empty_s & m.ready & ~clr;
   assign head_s  = mem_r[rptr_r];

   // Words offered during a flush are accepted and dropped.
   assign s.ready = clr | ~full_s;
   assign m.valid = ~empty_s;
   assign m.data  = head_s[DW-1:0];
   assign m.last  = head_s[DW];
   assign count   = count_r;
   assign len_err = len_err_r;

   // Packet framing for the word being pushed: stored last flag, next beat
   // count and whether this word reveals a length mismatch.
   always_comb begin
      last_out_s = 1'b0;
      err_s      = 1'b0;
      beat_nxt_s = beat_r + LW'(1);
      if (len != {LW{1'b0}}) begin
         if (beat_r == (len - LW'(1))) begin
            // Programmed length reached: close the packet regardless of s.last.
            last_out_s = 1'b1;
            beat_nxt_s = {LW{1'b0}};
            err_s      = ~s.last;
         end else if (s.last) begin
            // Upstream ended early: still pass the end through, flag it.
            last_out_s = 1'b1;
            beat_nxt_s = {LW{1'b0}};
            err_s      = 1'b1;
         end else begin
            last_out_s = 1'b0;
            beat_nxt_s = beat_r + LW'(1);
            err_s      = 1'b0;
         end
      end else begin
         last_out_s = s.last;
         err_s      = 1'b0;
         if (s.last) begin
            beat_nxt_s = {LW{1'b0}};
         end else begin
            beat_nxt_s = beat_r + LW'(1);
         end
      end
   end

   // Storage array; written on push only, left unreset since m.data is
   // don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r] <= {last_out_s, s.data};
      end
   end

   // Pointers, occupancy, beat counter and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r    <= {AW{1'b0}};
         rptr_r    <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         beat_r    <= {LW{1'b0}};
         len_err_r <= 1'b0;
      end else if (clr) begin
         wptr_r    <= {AW{1'b0}};
         rptr_r    <= {AW{1'b0}};
         count_r   <= {CW{1'b0}};
         beat_r    <= {LW{1'b0}};
         len_err_r <= 1'b0;
      end else begin
         if (push_s) begin
            wptr_r    <= wptr_r + AW'(1);
            beat_r    <= beat_nxt_s;
            len_err_r <= len_err_r | err_s;
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: doc/dst_stream_fifo.md
Name: dst_stream_fifo

Overview:
- Output-side buffer between the accelerator top's dst stream (dst_valid/dst_data/dst_last/dst_ready) and the DMA write master.
- Absorbs DMA backpressure with a first-word-fall-through FIFO.
- Carries fp32 words as raw bits.
- Checks each packet against the programmed output length (ds words) and forces a correct last flag toward the DMA.

Parameters:
DW, 32, data width in bits (fp32 bit pattern)
DEPTH, 16, FIFO entries; power of two, at least 2
LW, 12, width of the length and beat counter (matches ds)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush: empties FIFO, zeroes beat counter, clears len_err
len  in  LW  expected words per packet (ds); 0 disables the length check
s_valid  in  1  upstream word valid (dst_valid)
s_data  in  DW  upstream word (dst_data bits)
s_last  in  1  upstream last (dst_last)
s_ready  out  1  FIFO can accept (drives dst_ready)
m_valid  out  1  word available to DMA
m_data  out  DW  head word
m_last  out  1  head word ends packet
m_ready  in  1  DMA accepts
count  out  $clog2(DEPTH)+1  current occupancy
len_err  out  1  sticky length-mismatch flag

Behaviour:
- Reset (rst_n low, asynchronous): count=0, write and read pointers 0, beat counter 0, len_err=0, m_valid=0. m_data and m_last are don't-care while m_valid=0. s_ready=1 once rst_n is high.
- Push: s_valid & s_ready. Pop: m_valid & m_ready.
- s_ready = (count != DEPTH), decoded from registered count. There is no same-cycle bypass: when full, s_ready is 0 even if a pop occurs in that cycle.
- FWFT: m_valid = (count != 0). m_data and m_last present the head entry combinationally from registered storage.
- Latency: a word pushed in cycle N gives m_valid=1 in cycle N+1 if the FIFO was empty. Empty FIFO never passes data combinationally from s to m.
- count update per cycle: +1 push only, -1 pop only, unchanged for both or neither. Pointers wrap modulo DEPTH.
- Simultaneous push and pop at count=1 keeps m_valid=1 and advances head to the new word.
- Each entry stores {last_out, data}.
- Beat counter (input side, LW bits) increments on each push.
- With len != 0:
  - Push with beat==len-1: stored last_out=1; beat returns to 0. If s_last=0, set len_err.
  - Push with beat!=len-1 and s_last=1: stored last_out=1; beat returns to 0; set len_err.
  - Otherwise: last_out=0; beat increments.
- With len == 0: last_out = s_last; beat returns to 0 on s_last, else increments with natural wrap. len_err is never set.
- len is sampled on every push; software changes it only between packets. A mid-packet change takes effect on the next push.
- len_err is sticky until clr or reset.
- clr has priority over push and pop in the same cycle. Data presented during clr is dropped, and s_ready stays 1 during clr.
- Reset asserted mid-packet aborts the packet immediately. Partial data is lost and no m_last is produced.
- Upstream must hold s_data/s_last stable while s_valid=1 and s_ready=0. The block does not check this.

Test Plan:
- Basic flow: len=4, m_ready=1, push 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (s_last on 4th) -> same words on m_data one cycle later each, m_last only on 4th, len_err=0, count ≤1.
- Backpressure/full: DEPTH=16, m_ready=0, offer 20 words -> s_ready drops after 16 accepted, count=16. Raise m_ready -> 16 words out in order, then remaining 4 accepted, no loss or duplicate.
- Push+pop while full: count=16, s_valid=1, m_ready=1 for one cycle -> one pop, no push, count=15. Next cycle push accepted.
- Length mismatch: len=3, send 5 words with s_last on 5th -> m_last on word 3 and word 5, len_err=1 after word 3, stays 1. clr -> len_err=0, count=0.
- Check disabled: len=0, send 7 words with s_last on 7th -> m_last only on 7th, len_err=0. Beat counter restarts; next packet of 2 gives m_last on its 2nd word.
- Async reset mid-packet: rst_n low between clock edges with count=5 -> m_valid, count, len_err = 0 immediately without waiting for clk. After release, a fresh 4-word packet with len=4 passes correctly.
